// File: rtl/ultrasonic_phase_scheduler_if.sv
// Configuration and commit handshake between the register file and the
// phase scheduler. The channel field carries one extra bit so that
// out-of-range channel numbers can reach the scheduler and be rejected.
interface ultrasonic_phase_scheduler_if #(
   parameter int NUM_CH = 16,
   parameter int CNT_W  = 12
);
   localparam int CH_W = $clog2(NUM_CH + 1);

   logic             cfg_wr_en;
   logic [CH_W-1:0]  cfg_wr_ch;
   logic [CNT_W-1:0] cfg_wr_phase;
   logic [CNT_W-1:0] cfg_wr_duty;
   logic [CNT_W-1:0] cfg_period;
   logic             commit_req;
   logic             commit_busy;
   logic             commit_done;
   logic             cfg_wr_err;

   modport master (
      output cfg_wr_en, cfg_wr_ch, cfg_wr_phase, cfg_wr_duty, cfg_period, commit_req,
      input  commit_busy, commit_done, cfg_wr_err
   );

   modport slave (
      input  cfg_wr_en, cfg_wr_ch, cfg_wr_phase, cfg_wr_duty, cfg_period, commit_req,
      output commit_busy, commit_done, cfg_wr_err
   );
endinterface

// File: rtl/ultrasonic_phase_scheduler.sv
// Per-channel phase/duty PWM scheduler with shadow/active banks.
// Shadow writes are swapped into the active bank only on a period boundary
// (or immediately while the counter is stopped), so no period is ever torn.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | shadow bank writable; commit_req starts a commit
//   ST_PENDING | commit armed, waiting for pwm_cnt == active period
module ultrasonic_phase_scheduler #(
   parameter int NUM_CH         = 16,
   parameter int CNT_W          = 12,
   parameter int PERIOD_DEFAULT = 2499
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic                       enable,
   ultrasonic_phase_scheduler_if.slave cfg,
   output logic                       period_start,
   output logic [CNT_W-1:0]           pwm_cnt,
   output logic [NUM_CH-1:0]          pwm_out
);
   localparam int               CH_W    = $clog2(NUM_CH + 1);
   localparam logic [CNT_W-1:0] PER_RST = CNT_W'(PERIOD_DEFAULT);

   typedef enum logic {ST_IDLE, ST_PENDING} state_t;
   state_t state_q, state_d;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  per_q, per_d;
   logic [CNT_W-1:0]  sh_per_q, sh_per_d;
   logic [CNT_W-1:0]  act_ph_q [NUM_CH];
   logic [CNT_W-1:0]  act_ph_d [NUM_CH];
   logic [CNT_W-1:0]  act_du_q [NUM_CH];
   logic [CNT_W-1:0]  act_du_d [NUM_CH];
   logic [CNT_W-1:0]  sh_ph_q  [NUM_CH];
   logic [CNT_W-1:0]  sh_ph_d  [NUM_CH];
   logic [CNT_W-1:0]  sh_du_q  [NUM_CH];
   logic [CNT_W-1:0]  sh_du_d  [NUM_CH];
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              busy, sh_wr, per_load, swap;
   logic              at_end, ch_ok;
   logic [CNT_W:0]    diff;

   assign at_end = (cnt_q == per_q);
   assign ch_ok  = (cfg.cfg_wr_ch < CH_W'(NUM_CH));

   // State register
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next-state: a commit with the counter running waits for the boundary
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (cfg.commit_req && enable) state_d = ST_PENDING;
         ST_PENDING: if (!enable || at_end)        state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: write acceptance, rejection and swap timing
   always_comb begin
      busy     = 1'b0;
      sh_wr    = 1'b0;
      per_load = 1'b0;
      swap     = 1'b0;
      err_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sh_wr    = cfg.cfg_wr_en && ch_ok;
            err_d    = cfg.cfg_wr_en && !ch_ok;
            per_load = cfg.commit_req;
            swap     = cfg.commit_req && !enable;
         end
         ST_PENDING: begin
            busy  = 1'b1;
            err_d = cfg.cfg_wr_en || cfg.commit_req;
            swap  = !enable || at_end;
         end
         default: ;
      endcase
      done_d = swap;
   end

   // Banks and counter; a direct swap from IDLE includes the same-cycle write
   always_comb begin
      sh_per_d = per_load ? cfg.cfg_period : sh_per_q;
      for (int i = 0; i < NUM_CH; i++) begin
         sh_ph_d[i] = sh_ph_q[i];
         sh_du_d[i] = sh_du_q[i];
         if (sh_wr && (cfg.cfg_wr_ch == CH_W'(i))) begin
            sh_ph_d[i] = cfg.cfg_wr_phase;
            sh_du_d[i] = cfg.cfg_wr_duty;
         end
         act_ph_d[i] = swap ? sh_ph_d[i] : act_ph_q[i];
         act_du_d[i] = swap ? sh_du_d[i] : act_du_q[i];
      end
      per_d = swap ? sh_per_d : per_q;
      if (!enable || swap || (cnt_q >= per_q)) cnt_d = '0;
      else                                     cnt_d = cnt_q + CNT_W'(1);
   end

   // PWM compare on the phase-shifted count, using the active bank
   always_comb begin
      diff  = '0;
      pwm_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cnt_q >= act_ph_q[i])
            diff = {1'b0, cnt_q} - {1'b0, act_ph_q[i]};
         else
            diff = {1'b0, cnt_q} + {1'b0, per_q} + (CNT_W+1)'(1) - {1'b0, act_ph_q[i]};
         pwm_d[i] = enable && (act_ph_q[i] <= per_q) && (diff < {1'b0, act_du_q[i]});
      end
   end

   // Datapath registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cnt_q    <= '0;
         per_q    <= PER_RST;
         sh_per_q <= PER_RST;
         pwm_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            act_ph_q[i] <= '0;
            act_du_q[i] <= '0;
            sh_ph_q[i]  <= '0;
            sh_du_q[i]  <= '0;
         end
      end else begin
         cnt_q    <= cnt_d;
         per_q    <= per_d;
         sh_per_q <= sh_per_d;
         pwm_q    <= pwm_d;
         done_q   <= done_d;
         err_q    <= err_d;
         for (int i = 0; i < NUM_CH; i++) begin
            act_ph_q[i] <= act_ph_d[i];
            act_du_q[i] <= act_du_d[i];
            sh_ph_q[i]  <= sh_ph_d[i];
            sh_du_q[i]  <= sh_du_d[i];
         end
      end
   end

   assign period_start    = enable && (cnt_q == '0);
   assign pwm_cnt         = cnt_q;
   assign pwm_out         = pwm_q;
   assign cfg.commit_busy = busy;
   assign cfg.commit_done = done_q;
   assign cfg.cfg_wr_err  = err_q;
endmodule
